// File: rtl/crc_stream_pkg.sv
// Shared types and helpers for the streaming CRC engine family.
package crc_stream_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } crc_state_e;

   localparam logic [31:0] CRC_DEF_POLY = 32'h0000_0005;
   localparam logic [31:0] CRC_DEF_INIT = 32'h0000_0000;

   // Reverses the low i_w bits of i_v; the result is right-aligned.
   function automatic logic [31:0] bit_reverse(input logic [31:0] i_v, input int unsigned i_w);
      logic [31:0] w_r;
      w_r = '0;
      for (int unsigned i = 0; i < 32; i++) begin
         w_r[i] = i_v[31-i];
      end
      return w_r >> (32 - i_w);
   endfunction

endpackage

// File: rtl/crc_lfsr_step.sv
// Combinational CRC advance: shifts CRC_W-bit register by 1..DATA_W data bits in one step.
module crc_lfsr_step #(
   parameter int unsigned CRC_W     = 5,
   parameter int unsigned DATA_W    = 8,
   parameter logic [31:0] POLY      = 32'h0000_0005,
   parameter bit          LSB_FIRST = 1'b0
) (
   input  logic [CRC_W-1:0]            i_crc,
   input  logic [DATA_W-1:0]           i_data,
   input  logic [$clog2(DATA_W+1)-1:0] i_nbits,
   output logic [CRC_W-1:0]            o_crc
);

   localparam int unsigned NB_W = $clog2(DATA_W + 1);

   logic [NB_W:0] w_count;

   always_comb begin
      w_count = (i_nbits == '0) ? (NB_W+1)'(DATA_W) : {1'b0, i_nbits};
   end

   always_comb begin : step
      logic [CRC_W-1:0] w_reg;
      logic             w_d;
      logic             w_fb;
      w_reg = i_crc;
      w_d   = 1'b0;
      w_fb  = 1'b0;
      // Bits past the count are simply not applied, so trailing beat bits are ignored.
      for (int unsigned i = 0; i < DATA_W; i++) begin
         w_d  = LSB_FIRST ? i_data[i] : i_data[DATA_W-1-i];
         w_fb = w_reg[CRC_W-1] ^ w_d;
         if (i < 32'(w_count)) begin
            w_reg = {w_reg[CRC_W-2:0], 1'b0} ^ (w_fb ? POLY[CRC_W-1:0] : '0);
         end
      end
      o_crc = w_reg;
   end

endmodule

// File: rtl/crc_stream_engine.sv
// Streaming CRC generator/checker with valid/ready framing and a result handshake.
// Optional CRC_STREAM_CHECK_EN adds m_crc_ok (raw register compared against RESIDUE).
module crc_stream_engine
   import crc_stream_pkg::*;
#(
   parameter int unsigned CRC_W     = 5,
   parameter logic [31:0] POLY      = CRC_DEF_POLY,
   parameter logic [31:0] INIT      = CRC_DEF_INIT,
   parameter logic [31:0] XOR_OUT   = 32'h0000_0000,
   parameter bit          LSB_FIRST = 1'b0,
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned LEN_W     = 16,
   parameter logic [31:0] RESIDUE   = 32'h0000_0000
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        s_valid,
   output logic                        s_ready,
   input  logic [DATA_W-1:0]           s_data,
   input  logic                        s_first,
   input  logic                        s_last,
   input  logic [$clog2(DATA_W+1)-1:0] s_nbits,
   output logic                        m_valid,
   input  logic                        m_ready,
   output logic [CRC_W-1:0]            m_crc,
   output logic [LEN_W-1:0]            m_len,
`ifdef CRC_STREAM_CHECK_EN
   output logic                        m_crc_ok,
`endif
   output logic                        restart
);

   localparam int unsigned NB_W  = $clog2(DATA_W + 1);
   localparam int unsigned SUM_W = ((LEN_W > NB_W) ? LEN_W : NB_W) + 1;

   if (CRC_W < 2 || CRC_W > 32) begin : g_chk_crc_w
      $error("crc_stream_engine: CRC_W must be 2..32");
   end
   if (DATA_W < 1 || DATA_W > 64) begin : g_chk_data_w
      $error("crc_stream_engine: DATA_W must be 1..64");
   end
   if ((POLY >> CRC_W) != '0 || (INIT >> CRC_W) != '0 ||
       (XOR_OUT >> CRC_W) != '0 || (RESIDUE >> CRC_W) != '0) begin : g_chk_consts
      $error("crc_stream_engine: constant wider than CRC_W");
   end

   crc_state_e       r_state;
   logic             r_ready;
   logic             r_mvalid;
   logic             r_restart;
   logic [CRC_W-1:0] r_crc;
   logic [CRC_W-1:0] r_mcrc;
   logic [LEN_W-1:0] r_len;
   logic [LEN_W-1:0] r_mlen;

   logic             w_xfer;
   logic             w_seed;
   logic [CRC_W-1:0] w_crc_base;
   logic [CRC_W-1:0] w_crc_next;
   logic [CRC_W-1:0] w_crc_out;
   logic [NB_W-1:0]  w_nbits;
   logic [NB_W:0]    w_beat_bits;
   logic [LEN_W-1:0] w_len_base;
   logic [SUM_W-1:0] w_len_sum;
   logic [LEN_W-1:0] w_len_next;

   always_comb begin
      w_xfer      = s_valid && r_ready;
      // IDLE always starts a fresh frame; RUN restarts only on s_first.
      w_seed      = (r_state == ST_IDLE) || s_first;
      w_crc_base  = w_seed ? INIT[CRC_W-1:0] : r_crc;
      w_len_base  = w_seed ? '0 : r_len;
      w_nbits     = s_last ? s_nbits : '0;
      w_beat_bits = (w_nbits == '0) ? (NB_W+1)'(DATA_W) : {1'b0, w_nbits};
      w_len_sum   = SUM_W'(w_len_base) + SUM_W'(w_beat_bits);
      w_len_next  = (w_len_sum > SUM_W'({LEN_W{1'b1}})) ? '1 : w_len_sum[LEN_W-1:0];
      w_crc_out   = (LSB_FIRST ? CRC_W'(bit_reverse(32'(w_crc_next), CRC_W)) : w_crc_next)
                    ^ XOR_OUT[CRC_W-1:0];
   end

   crc_lfsr_step #(
      .CRC_W     (CRC_W),
      .DATA_W    (DATA_W),
      .POLY      (POLY),
      .LSB_FIRST (LSB_FIRST)
   ) u_step (
      .i_crc   (w_crc_base),
      .i_data  (s_data),
      .i_nbits (w_nbits),
      .o_crc   (w_crc_next)
   );

`ifdef CRC_STREAM_CHECK_EN
   logic r_crc_ok;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_crc_ok <= 1'b0;
      end else if (w_xfer && s_last) begin
         r_crc_ok <= (w_crc_next == RESIDUE[CRC_W-1:0]);
      end
   end
   assign m_crc_ok = r_crc_ok;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_ready   <= 1'b0;
         r_mvalid  <= 1'b0;
         r_restart <= 1'b0;
         r_crc     <= INIT[CRC_W-1:0];
         r_len     <= '0;
         r_mcrc    <= '0;
         r_mlen    <= '0;
      end else begin
         r_restart <= 1'b0;
         case (r_state)
            ST_IDLE, ST_RUN: begin
               r_ready <= 1'b1;
               if (w_xfer) begin
                  r_crc     <= w_crc_next;
                  r_len     <= w_len_next;
                  r_restart <= s_first && (r_state == ST_RUN);
                  if (s_last) begin
                     r_state  <= ST_HOLD;
                     r_ready  <= 1'b0;
                     r_mvalid <= 1'b1;
                     r_mcrc   <= w_crc_out;
                     r_mlen   <= w_len_next;
                  end else begin
                     r_state <= ST_RUN;
                  end
               end
            end
            ST_HOLD: begin
               r_ready <= 1'b0;
               if (m_ready) begin
                  r_state  <= ST_IDLE;
                  r_mvalid <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_ready <= 1'b0;
            end
         endcase
      end
   end

   assign s_ready = r_ready;
   assign m_valid = r_mvalid;
   assign m_crc   = r_mcrc;
   assign m_len   = r_mlen;
   assign restart = r_restart;

endmodule

// File: tb/tb_crc_stream_engine.sv
// Directed bench for crc_stream_engine: default CRC-5, CRC-5/USB, and a short-LEN_W instance.
module tb_crc_stream_engine;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Port 0 drives u_dut0 (defaults) and u_dut2 (LEN_W=4); port 1 drives u_dut1 (CRC-5/USB).
   logic [1:0]  s_valid, s_first, s_last, m_ready;
   logic [7:0]  s_data  [2];
   logic [3:0]  s_nbits [2];
   logic [2:0]  s_ready, m_valid, restart;
   logic [4:0]  m_crc   [3];
   logic [15:0] m_len0, m_len1;
   logic [3:0]  m_len2;
`ifdef CRC_STREAM_CHECK_EN
   logic [2:0]  m_crc_ok;
`endif

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   crc_stream_engine u_dut0 (
      .clk(clk), .rst(rst), .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_data(s_data[0]),
      .s_first(s_first[0]), .s_last(s_last[0]), .s_nbits(s_nbits[0]), .m_valid(m_valid[0]),
      .m_ready(m_ready[0]), .m_crc(m_crc[0]), .m_len(m_len0),
`ifdef CRC_STREAM_CHECK_EN
      .m_crc_ok(m_crc_ok[0]),
`endif
      .restart(restart[0])
   );

   crc_stream_engine #(
      .CRC_W(5), .POLY(32'h05), .INIT(32'h1F), .XOR_OUT(32'h1F), .LSB_FIRST(1'b1)
   ) u_dut1 (
      .clk(clk), .rst(rst), .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_data(s_data[1]),
      .s_first(s_first[1]), .s_last(s_last[1]), .s_nbits(s_nbits[1]), .m_valid(m_valid[1]),
      .m_ready(m_ready[1]), .m_crc(m_crc[1]), .m_len(m_len1),
`ifdef CRC_STREAM_CHECK_EN
      .m_crc_ok(m_crc_ok[1]),
`endif
      .restart(restart[1])
   );

   crc_stream_engine #(
      .LEN_W(4)
   ) u_dut2 (
      .clk(clk), .rst(rst), .s_valid(s_valid[0]), .s_ready(s_ready[2]), .s_data(s_data[0]),
      .s_first(s_first[0]), .s_last(s_last[0]), .s_nbits(s_nbits[0]), .m_valid(m_valid[2]),
      .m_ready(m_ready[0]), .m_crc(m_crc[2]), .m_len(m_len2),
`ifdef CRC_STREAM_CHECK_EN
      .m_crc_ok(m_crc_ok[2]),
`endif
      .restart(restart[2])
   );

   typedef struct {
      logic [7:0]  data;
      logic        first;
      logic [3:0]  nbits;
      logic [4:0]  crc;
      logic [15:0] len;
   } vec_t;

   vec_t vecs [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic send(input int unsigned p, input logic [7:0] d, input logic f,
                       input logic l, input logic [3:0] nb);
      int unsigned n;
      @(negedge clk);
      s_data[p]  = d;
      s_first[p] = f;
      s_last[p]  = l;
      s_nbits[p] = nb;
      s_valid[p] = 1'b1;
      n = 0;
      while (!s_ready[p] && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!s_ready[p]) begin
         n_checks++;
         n_fail++;
         $display("FAIL ready_wait: port %0d s_ready still 0 after %0d cycles", p, n);
      end
      @(posedge clk);
      #1;
      s_valid[p] = 1'b0;
      s_first[p] = 1'b0;
      s_last[p]  = 1'b0;
   endtask

   task automatic get_result(input int unsigned p, input string name,
                             input logic [4:0] exp_crc, input logic [15:0] exp_len);
      int unsigned n;
      n = 0;
      while (!m_valid[p] && n < 40) begin
         @(negedge clk);
         n++;
      end
      check({name, "_valid"}, 32'(m_valid[p]), 32'd1);
      check({name, "_crc"}, 32'(m_crc[p]), 32'(exp_crc));
      if (p == 0) begin
         check({name, "_len"}, 32'(m_len0), 32'(exp_len));
         check({name, "_crc_l4"}, 32'(m_crc[2]), 32'(exp_crc));
         check({name, "_len_l4"}, 32'(m_len2), (exp_len > 16'd15) ? 32'd15 : 32'(exp_len));
      end else begin
         check({name, "_len"}, 32'(m_len1), 32'(exp_len));
      end
      @(negedge clk);
      m_ready[p] = 1'b1;
      @(posedge clk);
      #1;
      m_ready[p] = 1'b0;
      check({name, "_valid_drop"}, 32'(m_valid[p]), 32'd0);
   endtask

   initial begin
      int unsigned bub [9];
      logic [7:0]  msg [9];

      vecs[0] = '{8'h80, 1'b1, 4'd0, 5'h0E, 16'd8};
      vecs[1] = '{8'h01, 1'b1, 4'd0, 5'h05, 16'd8};
      vecs[2] = '{8'h00, 1'b1, 4'd0, 5'h00, 16'd8};
      vecs[3] = '{8'h81, 1'b1, 4'd0, 5'h0B, 16'd8};
      vecs[4] = '{8'h40, 1'b0, 4'd0, 5'h07, 16'd8};
      vecs[5] = '{8'h03, 1'b1, 4'd0, 5'h0F, 16'd8};
      vecs[6] = '{8'h80, 1'b1, 4'd1, 5'h05, 16'd1};
      vecs[7] = '{8'h8F, 1'b1, 4'd4, 5'h0D, 16'd4};
      vecs[8] = '{8'hFF, 1'b1, 4'd8, 5'h14, 16'd8};
      vecs[9] = '{8'h7F, 1'b1, 4'd1, 5'h00, 16'd1};
      bub = '{0, 2, 0, 1, 3, 0, 0, 1, 2};
      msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

      rst     = 1'b1;
      s_valid = '0;
      s_first = '0;
      s_last  = '0;
      m_ready = '0;
      for (int i = 0; i < 2; i++) begin
         s_data[i]  = '0;
         s_nbits[i] = '0;
      end

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_s_ready", 32'(s_ready), 32'd0);
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_m_crc", 32'(m_crc[0]), 32'd0);
      check("rst_m_len", 32'(m_len0), 32'd0);
      check("rst_restart", 32'(restart), 32'd0);
      rst = 1'b0;
      #1;
      check("rst_rel_ready0", 32'(s_ready[0]), 32'd0);
      @(posedge clk);
      #1;
      check("rst_rel_ready1", 32'(s_ready[0]), 32'd1);

      // Single beat 0x80, result the cycle after the beat
      check("t1_pre_valid", 32'(m_valid[0]), 32'd0);
      send(0, 8'h80, 1'b1, 1'b1, 4'd0);
      check("t1_latency", 32'(m_valid[0]), 32'd1);
      get_result(0, "t1", 5'h0E, 16'd8);

      // Result held while m_ready low, then one bubble before s_ready returns
      send(0, 8'h01, 1'b1, 1'b1, 4'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t2_hold_valid", 32'(m_valid[0]), 32'd1);
         check("t2_hold_ready", 32'(s_ready[0]), 32'd0);
         check("t2_hold_crc", 32'(m_crc[0]), 32'h05);
      end
      get_result(0, "t2", 5'h05, 16'd8);
      check("t2_bubble", 32'(s_ready[0]), 32'd0);
      @(posedge clk);
      #1;
      check("t2_ready_back", 32'(s_ready[0]), 32'd1);

      for (int i = 0; i < 10; i++) begin
         send(0, vecs[i].data, vecs[i].first, 1'b1, vecs[i].nbits);
         get_result(0, $sformatf("vec%0d", i), vecs[i].crc, vecs[i].len);
      end

      // Two-beat frame; LEN_W=4 instance saturates at 15
      send(0, 8'h80, 1'b1, 1'b0, 4'd0);
      send(0, 8'h00, 1'b0, 1'b1, 4'd0);
      get_result(0, "sat", 5'h0C, 16'd16);

      // Message followed by its CRC in a 5-bit partial beat
      send(0, 8'h80, 1'b1, 1'b0, 4'd0);
      send(0, 8'b01110_000, 1'b0, 1'b1, 4'd5);
`ifdef CRC_STREAM_CHECK_EN
      check("t4_ok", 32'(m_crc_ok[0]), 32'd1);
`endif
      get_result(0, "t4a", 5'h00, 16'd13);
      send(0, 8'h80, 1'b1, 1'b0, 4'd0);
      send(0, 8'b01111_000, 1'b0, 1'b1, 4'd5);
`ifdef CRC_STREAM_CHECK_EN
      check("t4_bad", 32'(m_crc_ok[0]), 32'd0);
`endif
      get_result(0, "t4b", 5'h05, 16'd13);
      send(0, 8'h80, 1'b1, 1'b0, 4'd0);
      send(0, 8'b01110_111, 1'b0, 1'b1, 4'd5);
`ifdef CRC_STREAM_CHECK_EN
      check("t4_ign", 32'(m_crc_ok[0]), 32'd1);
`endif
      get_result(0, "t4c", 5'h00, 16'd13);

      // s_first on the third beat restarts the frame
      send(0, 8'h12, 1'b1, 1'b0, 4'd0);
      send(0, 8'h34, 1'b0, 1'b0, 4'd0);
      check("t5_no_restart", 32'(restart[0]), 32'd0);
      send(0, 8'h80, 1'b1, 1'b0, 4'd0);
      check("t5_restart", 32'(restart[0]), 32'd1);
      send(0, 8'h01, 1'b0, 1'b1, 4'd0);
      check("t5_restart_end", 32'(restart[0]), 32'd0);
      get_result(0, "t5", 5'h09, 16'd16);

      // CRC-5/USB over "123456789" with idle gaps
      for (int i = 0; i < 9; i++) begin
         repeat (bub[i]) @(negedge clk);
         send(1, msg[i], (i == 0), (i == 8), 4'd0);
      end
      get_result(1, "usb", 5'h19, 16'd72);

      // Reset in RUN
      send(0, 8'h12, 1'b1, 1'b0, 4'd0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("t6r_valid", 32'(m_valid[0]), 32'd0);
      check("t6r_ready", 32'(s_ready[0]), 32'd0);
      check("t6r_crc", 32'(m_crc[0]), 32'd0);
      check("t6r_len", 32'(m_len0), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      send(0, 8'h80, 1'b1, 1'b1, 4'd0);
      get_result(0, "t6r_next", 5'h0E, 16'd8);

      // Reset in HOLD
      send(0, 8'h01, 1'b1, 1'b1, 4'd0);
      @(negedge clk);
      check("t6h_pre", 32'(m_valid[0]), 32'd1);
      rst = 1'b1;
      #1;
      check("t6h_valid", 32'(m_valid[0]), 32'd0);
      check("t6h_crc", 32'(m_crc[0]), 32'd0);
      check("t6h_len", 32'(m_len0), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      send(0, 8'h80, 1'b1, 1'b1, 4'd0);
      get_result(0, "t6h_next", 5'h0E, 16'd8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
